// File: rtl/pipeline_hazard_controller.sv
// Stall/hold/flush sequencer for the 5-stage MIPS pipeline (load-use, multi-cycle HI/LO, taken branch).
// Optional performance counters are enabled by defining HAZARD_PERF_CNT_EN.
module pipeline_hazard_controller #(
    parameter int MULT_CYCLES = 4,
    parameter int CNT_W       = 4
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic [4:0] Rs_ID,
    input  logic [4:0] Rt_ID,
    input  logic       UsesRt_ID,
    input  logic       MemRead_EX,
    input  logic [4:0] WriteRegister_EX,
    input  logic       Branch_EX,
    input  logic       Zero_EX,
    input  logic       MultStart_EX,
    output logic       PCWrite,
    output logic       IF_ID_Write,
    output logic       IF_ID_Flush,
    output logic       ID_EX_Bubble,
    output logic       EX_Hold,
    output logic       Busy
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0] StallCycles,
    output logic [31:0] FlushCount
`endif
);

    typedef enum logic [1:0] {RUN, MUL_WAIT, MUL_LAST} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             branch_taken;
    logic             load_use;

    assign branch_taken = Branch_EX & Zero_EX;
    assign load_use     = MemRead_EX & (WriteRegister_EX != 5'd0) &
                          ((WriteRegister_EX == Rs_ID) | (UsesRt_ID & (WriteRegister_EX == Rt_ID)));

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        PCWrite      = 1'b1;
        IF_ID_Write  = 1'b1;
        IF_ID_Flush  = 1'b0;
        ID_EX_Bubble = 1'b0;
        EX_Hold      = 1'b0;
        Busy         = 1'b0;
        case (state_q)
            RUN: begin
                if (branch_taken) begin
                    IF_ID_Flush  = 1'b1;
                    ID_EX_Bubble = 1'b1;
                end else if (MultStart_EX) begin
                    PCWrite     = 1'b0;
                    IF_ID_Write = 1'b0;
                    EX_Hold     = 1'b1;
                    Busy        = 1'b1;
                    state_d     = MUL_WAIT;
                    cnt_d       = CNT_W'(MULT_CYCLES - 2);
                end else if (load_use) begin
                    PCWrite      = 1'b0;
                    IF_ID_Write  = 1'b0;
                    ID_EX_Bubble = 1'b1;
                end
            end
            MUL_WAIT: begin
                PCWrite     = 1'b0;
                IF_ID_Write = 1'b0;
                EX_Hold     = 1'b1;
                Busy        = 1'b1;
                if (cnt_q == '0) begin
                    state_d = MUL_LAST;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            MUL_LAST: begin
                // The departing op still drives MultStart_EX here, so it must not re-arm.
                Busy    = 1'b1;
                state_d = RUN;
            end
            default: state_d = RUN;
        endcase
        if (Rst) begin
            PCWrite      = 1'b0;
            IF_ID_Write  = 1'b0;
            IF_ID_Flush  = 1'b1;
            ID_EX_Bubble = 1'b1;
            EX_Hold      = 1'b0;
            Busy         = 1'b0;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_q, flush_q;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (!PCWrite && (stall_q != 32'hFFFF_FFFF)) stall_q <= stall_q + 32'd1;
            if (IF_ID_Flush && (flush_q != 32'hFFFF_FFFF)) flush_q <= flush_q + 32'd1;
        end
    end

    assign StallCycles = stall_q;
    assign FlushCount  = flush_q;
`endif

endmodule
